// File: rtl/mandel_pkg.sv
// mandel_pkg: FSM state codes, default Q-format sizes and fixed-point helpers shared by the Mandelbrot cores and scan controller.
package mandel_pkg;
    localparam int W_DEF    = 16;
    localparam int FRAC_DEF = 12;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_MXX   = 3'd1;
    localparam logic [2:0] S_MYY   = 3'd2;
    localparam logic [2:0] S_MXY   = 3'd3;
    localparam logic [2:0] S_CHECK = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    function automatic logic signed [63:0] sat_w(input logic signed [63:0] v, input int w);
        logic signed [63:0] mx;
        logic signed [63:0] mn;
        mx = (64'sd1 <<< (w - 1)) - 64'sd1;
        mn = -mx - 64'sd1;
        return v > mx ? mx : v < mn ? mn : v;
    endfunction
    function automatic logic [63:0] four_q(input int frac);
        return 64'd4 << frac;
    endfunction
    localparam logic [63:0] FOUR = four_q(FRAC_DEF);
endpackage

// File: rtl/fxp_mul_sat.sv
// fxp_mul_sat: combinational signed WxW Q-format multiplier that saturates instead of wrapping.
module fxp_mul_sat #(
    parameter int W    = 16,
    parameter int FRAC = 12
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] p
);
    logic signed [2*W-1:0] prod;
    logic [W-FRAC:0] hi;
    assign prod = a * b;
    // Kept bits plus everything above must be pure sign extension to fit.
    assign hi = prod[2*W-1:FRAC+W-1];
    assign p = (&hi || ~|hi) ? prod[FRAC+W-1:FRAC]
             : prod[2*W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
endmodule

// File: rtl/mandelbrot_iter_core.sv
// mandelbrot_iter_core: escape-count engine for one point c, four cycles per iteration
// around a single shared saturating multiplier, valid/ready on both sides.
module mandelbrot_iter_core
    import mandel_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int FRAC   = FRAC_DEF,
    parameter int ITER_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W-1:0]        in_cx,
    input  logic [W-1:0]        in_cy,
    input  logic [ITER_W-1:0]   in_max_iter,
    input  logic                abort,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ITER_W-1:0]   out_iter,
    output logic                out_inside
);
    if (W - FRAC < 4) begin : g_chk
        $error("mandelbrot_iter_core: W-FRAC must be >= 4 to represent 4.0");
    end
    localparam logic [W:0] FOUR_Q = (W+1)'(four_q(FRAC));
    logic [2:0] state;
    logic signed [W-1:0] cx, cy, x, y, x2, y2, xy, ma, mb, mp;
    logic [ITER_W-1:0] n, iter;
    logic [W:0] s;
    logic signed [W+1:0] x_sum, y_sum;
    assign in_ready  = state == S_IDLE;
    assign out_valid = state == S_DONE;
    assign ma = state == S_MYY ? y : x;
    assign mb = state == S_MXX ? x : y;
    fxp_mul_sat #(.W(W), .FRAC(FRAC)) u_mul (.a(ma), .b(mb), .p(mp));
    // Squares are never negative, so the magnitude sum is taken unsigned with one carry bit.
    assign s     = {1'b0, x2} + {1'b0, y2};
    assign x_sum = (W+2)'(x2) - (W+2)'(y2) + (W+2)'(cx);
    assign y_sum = ((W+2)'(xy) <<< 1) + (W+2)'(cy);
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            out_iter   <= '0;
            out_inside <= 1'b0;
            x          <= '0;
            y          <= '0;
            iter       <= '0;
            cx         <= '0;
            cy         <= '0;
            n          <= '0;
            x2         <= '0;
            y2         <= '0;
            xy         <= '0;
        end else if (abort && state != S_IDLE) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    cx    <= in_cx;
                    cy    <= in_cy;
                    n     <= in_max_iter;
                    x     <= '0;
                    y     <= '0;
                    iter  <= '0;
                    state <= S_MXX;
                end
                S_MXX: begin
                    x2    <= mp;
                    state <= S_MYY;
                end
                S_MYY: begin
                    y2    <= mp;
                    state <= S_MXY;
                end
                S_MXY: begin
                    xy    <= mp;
                    state <= S_CHECK;
                end
                S_CHECK: if (s > FOUR_Q) begin
                    out_iter   <= iter;
                    out_inside <= 1'b0;
                    state      <= S_DONE;
                end else if (iter == n) begin
                    out_iter   <= n;
                    out_inside <= 1'b1;
                    state      <= S_DONE;
                end else begin
                    x     <= W'(sat_w(64'(x_sum), W));
                    y     <= W'(sat_w(64'(y_sum), W));
                    iter  <= iter + 1'b1;
                    state <= S_MXX;
                end
                S_DONE: if (out_ready) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
